// File: rtl/term_write_ctrl.sv
// ============================================================================
//  Module   : term_write_ctrl
//  Purpose  : UART byte sequencer / port arbiter for the 2048-byte terminal
//             character buffer. Optional macro: TERM_AUTOWRAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module term_write_ctrl #(
    parameter int COLS       = 64,
    parameter int ROWS       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    rd_req,
    input  logic [10:0]             rd_addr,
    output logic                    rd_valid,
    output logic [7:0]              rd_data,
    output logic                    mem_we,
    output logic [10:0]             mem_addr,
    output logic [7:0]              mem_din,
    input  logic [7:0]              mem_dout,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic [$clog2(ROWS)-1:0] cursor_row,
    output logic                    busy,
    output logic                    overflow
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [0:0]    c_st_idle  = 1'b0;
    localparam logic [0:0]    c_st_clear = 1'b1;
    localparam logic [7:0]    c_space    = 8'h20;
    localparam logic [CW-1:0] c_col_last = CW'(COLS - 1);
    localparam logic [CW-1:0] c_col_one  = CW'(1);
    localparam logic [RW-1:0] c_row_one  = RW'(1);
    localparam logic [PW:0]   c_ptr_one  = (PW+1)'(1);
    localparam logic [10:0]   c_clr_last = 11'h7FF;

    logic [0:0]    r_state, w_state_nxt;
    logic [CW-1:0] r_col, w_col_nxt;
    logic [RW-1:0] r_row, w_row_nxt;
    logic [10:0]   r_clr, w_clr_nxt;
    logic          r_rd_valid;
    logic          r_overflow;

    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW:0]   r_wptr, r_rptr;
    logic          w_empty, w_full, w_pop, w_push;
    logic [7:0]    w_head;

    logic          w_we;
    logic [10:0]   w_addr;
    logic [7:0]    w_din;

    // Extra pointer bit distinguishes full from empty
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_head  = r_fifo[r_rptr[PW-1:0]];
    assign w_pop   = (r_state == c_st_idle) && !rd_req && !w_empty;
    assign w_push  = rx_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr[PW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_col      <= '0;
            r_row      <= '0;
            r_clr      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_clr      <= w_clr_nxt;
            r_rd_valid <= rd_req;
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            if (rx_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_clr_nxt   = r_clr;
        w_we        = 1'b0;
        w_addr      = {r_row, r_col};
        w_din       = w_head;

        if (rd_req) begin
            // Display read owns the port; controller state holds
            w_addr = rd_addr;
        end else if (r_state == c_st_clear) begin
            w_we   = 1'b1;
            w_addr = r_clr;
            w_din  = c_space;
            if (r_clr == c_clr_last) begin
                w_state_nxt = c_st_idle;
                w_clr_nxt   = '0;
            end else begin
                w_clr_nxt = r_clr + 11'd1;
            end
        end else if (!w_empty) begin
            if ((w_head >= 8'h20) && (w_head <= 8'h7E)) begin
                w_we = 1'b1;
                if (r_col != c_col_last) begin
                    w_col_nxt = r_col + c_col_one;
                end else begin
`ifdef TERM_AUTOWRAP_EN
                    w_col_nxt = '0;
                    w_row_nxt = r_row + c_row_one;
`else
                    w_col_nxt = r_col;
`endif
                end
            end else begin
                case (w_head)
                    8'h0D: w_col_nxt = '0;
                    8'h0A: w_row_nxt = r_row + c_row_one;
                    8'h08: begin
                        if (r_col != '0) begin
                            w_col_nxt = r_col - c_col_one;
                            w_we      = 1'b1;
                            w_addr    = {r_row, r_col - c_col_one};
                            w_din     = c_space;
                        end
                    end
                    8'h0C: begin
                        w_state_nxt = c_st_clear;
                        w_clr_nxt   = '0;
                        w_col_nxt   = '0;
                        w_row_nxt   = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we     = w_we;
    assign mem_addr   = w_addr;
    assign mem_din    = w_din;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = mem_dout;
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign busy       = (r_state == c_st_clear);
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_term_write_ctrl.sv
// ============================================================================
//  Module   : tb_term_write_ctrl
//  Purpose  : Scoreboard bench for term_write_ctrl (expected writes queued by
//             stimulus, popped and compared by a monitor on negedge).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_term_write_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rd_req;
    logic [10:0] rd_addr;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;
    logic        overflow;

    term_write_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy),
        .overflow   (overflow)
    );

    typedef struct {
        logic [10:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  mem [2048];
    logic        exp_rdv;
    logic        stop_tog;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_rdv <= 1'b0;
        else        exp_rdv <= rd_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: port arbitration, read handshake and write scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_req) begin
                chk("rd_port_we", {31'd0, mem_we}, 32'd0);
                chk("rd_port_addr", {21'd0, mem_addr}, {21'd0, rd_addr});
            end
            chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_rdv});
            if (mem_we) begin
                if (q.size() == 0) begin
                    chk("spurious_write", {31'd0, mem_we}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("write_addr", {21'd0, mem_addr}, {21'd0, e.a});
                    chk("write_data", {24'd0, mem_din}, {24'd0, e.d});
                end
            end
        end
    end

    task automatic expect_wr(input logic [10:0] a, input logic [7:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && q.size() != 0; k++) @(negedge clk);
        chk("drain_left", q.size(), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rd_req   = 1'b0;
        q.delete();
        #2;
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_rdv", {31'd0, rd_valid}, 32'd0);
        chk("rst_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_req   = 1'b0;
        rd_addr  = 11'd0;
        stop_tog = 1'b0;
        #2;
        do_reset();

        // "AB"
        expect_wr(11'd0, 8'h41);
        expect_wr(11'd1, 8'h42);
        send(8'h41);
        send(8'h42);
        drain(20);
        chk("ab_col", {26'd0, cursor_col}, 32'd2);
        chk("ab_row", {27'd0, cursor_row}, 32'd0);

        // "X" CR LF "Y"
        do_reset();
        expect_wr(11'd0, 8'h58);
        expect_wr(11'd64, 8'h59);
        send(8'h58);
        send(8'h0D);
        send(8'h0A);
        send(8'h59);
        drain(20);
        chk("crlf_col", {26'd0, cursor_col}, 32'd1);
        chk("crlf_row", {27'd0, cursor_row}, 32'd1);

        // Backspace at col 3, then at col 0
        do_reset();
        expect_wr(11'd0, 8'h61);
        expect_wr(11'd1, 8'h62);
        expect_wr(11'd2, 8'h63);
        expect_wr(11'd2, 8'h20);
        send(8'h61);
        send(8'h62);
        send(8'h63);
        send(8'h08);
        drain(20);
        chk("bs_col", {26'd0, cursor_col}, 32'd2);
        send(8'h0D);
        send(8'h08);
        send(8'h15);
        repeat (4) @(posedge clk);
        #1;
        chk("bs0_col", {26'd0, cursor_col}, 32'd0);
        chk("bs0_row", {27'd0, cursor_row}, 32'd0);

        // Reads hold off writes; mem[64] holds 'Y'
        do_reset();
        rd_addr = 11'd64;
        rd_req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rd_data_64", {24'd0, rd_data}, 32'h59);
        @(posedge clk);
        #1;
        expect_wr(11'd0, 8'h31);
        expect_wr(11'd1, 8'h32);
        expect_wr(11'd2, 8'h33);
        send(8'h31);
        send(8'h32);
        send(8'h33);
        repeat (3) @(posedge clk);
        #1;
        chk("held_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("burst_we", {31'd0, mem_we}, 32'd1);
        end
        drain(10);
        chk("burst_col", {26'd0, cursor_col}, 32'd3);

        // Overflow: 6 bytes into a 4-deep FIFO while reads hold the port
        do_reset();
        rd_addr = 11'd5;
        rd_req  = 1'b1;
        for (int i = 0; i < 4; i++) expect_wr(11'(i), 8'h41 + 8'(i));
        for (int i = 0; i < 6; i++) send(8'h41 + 8'(i));
        @(negedge clk);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        @(posedge clk);
        #1 rd_req = 1'b0;
        drain(20);
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("ovf_col", {26'd0, cursor_col}, 32'd4);

        // Clear screen with rd_req toggling every 4 cycles
        do_reset();
        rd_addr = 11'd100;
        expect_wr(11'd0, 8'h51);
        for (int i = 0; i < 2048; i++) expect_wr(11'(i), 8'h20);
        fork
            begin
                while (!stop_tog) begin
                    repeat (4) @(posedge clk);
                    #1 rd_req = ~rd_req;
                end
            end
        join_none
        send(8'h51);
        send(8'h0C);
        for (int k = 0; k < 50 && !busy; k++) @(negedge clk);
        chk("clr_busy_rise", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 9000 && busy; k++) @(negedge clk);
        chk("clr_busy_fall", {31'd0, busy}, 32'd0);
        stop_tog = 1'b1;
        repeat (6) @(posedge clk);
        #1 rd_req = 1'b0;
        drain(10);
        bad = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== 8'h20) bad++;
        chk("clr_mem_bad", bad, 32'd0);
        chk("clr_cursor", {21'd0, cursor_row, cursor_col}, 32'd0);

        // Printable at the last column
        do_reset();
        for (int i = 0; i < 63; i++) begin
            expect_wr(11'(i), 8'h61);
            send(8'h61);
        end
        drain(100);
        chk("c63_col", {26'd0, cursor_col}, 32'd63);
        expect_wr(11'd63, 8'h5A);
`ifdef TERM_AUTOWRAP_EN
        expect_wr(11'd64, 8'h57);
`else
        expect_wr(11'd63, 8'h57);
`endif
        send(8'h5A);
        send(8'h57);
        drain(20);
`ifdef TERM_AUTOWRAP_EN
        chk("wrap_col", {26'd0, cursor_col}, 32'd1);
        chk("wrap_row", {27'd0, cursor_row}, 32'd1);
`else
        chk("wrap_col", {26'd0, cursor_col}, 32'd63);
        chk("wrap_row", {27'd0, cursor_row}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
